decoder_nto2n_seq: RTL
======================

# decoder_nto2n_seq

Registered, parametrised N-to-2^N one-hot decoder with a valid/ready input handshake, global output enable, and an auto-scan mode that steps through every output with a programmable dwell time. It succeeds the combinational 3-to-8 decoder. It sits between control logic and row/select fan-out (display multiplexing, bank select, chip-select strobing), where registered, glitch-free one-hot selects are required.

## Interface
- N, default 3: select width; output width is 2^N (N = 1..6).
- DWELL_W, default 8: width of the dwell input and the internal dwell counter.

- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- a  in  N  binary select (direct mode).
- a_valid  in  1  select valid.
- a_ready  out  1  block accepts `a`.
- en  in  1  output enable; 0 blanks outputs and freezes scan.
- mode  in  1  0 = direct, 1 = scan.
- dwell  in  DWELL_W  cycles each index is held in scan; 0 treated as 1.
- y  out  2^N  one-hot output, registered.
- idx  out  N  binary index of the active bit, registered.
- y_valid  out  1  `y` holds a decoded value.
- wrap  out  1  one-cycle pulse when scan returns from index 2^N-1 to 0.

## Operation
- FSM states: IDLE, DIRECT, SCAN. Reset → IDLE.
- Reset values: y=0, idx=0, y_valid=0, wrap=0, a_ready=0 during the rst cycle; dwell counter=0.
- a_ready = (state != SCAN) && !mode && !rst.
- Accept = a_valid && a_ready. On accept: idx ← a, y ← 1<<a, state → DIRECT. The value holds until the next accept.
- IDLE or DIRECT with mode=1 → SCAN. idx ← 0, dwell counter ← 0.
- SCAN:
  - Dwell counter increments each enabled cycle.
  - When counter ≥ max(dwell,1)-1: counter ← 0, idx ← idx+1 mod 2^N.
  - wrap=1 in the cycle idx transitions 2^N-1 → 0.
- SCAN with mode=0 → DIRECT. Keeps the current idx/y. a_ready rises the following cycle.
- en=0:
  - y ← 0 and y_valid ← 0 on the next edge.
  - idx, FSM state, and dwell counter are frozen. Scan resumes from the same idx and count.
  - Accepts are still taken; the stored idx is shown once en returns.
- y is always 0 or exactly one-hot. y == (en_q ? 1<<idx : 0), where en_q is en registered.
- y_valid = en_q && state != IDLE.
- dwell is compared live. Lowering it below the current count causes a step on the next cycle.
- a_valid while mode=1 is ignored. No accept occurs and no state change results.

## Timing
- Direct latency: accept at edge t → y/idx/y_valid updated after edge t (visible cycle t+1). Throughput is one select per cycle.
- Scan entry: mode sampled high at edge t → y = bit 0 from cycle t+1.
- Each index is held exactly max(dwell,1) enabled cycles. A full sweep takes 2^N·max(dwell,1) cycles.
- wrap is registered, coincident with the first cycle y = bit 0 of a new sweep. It does not pulse on initial scan entry.
- en toggling takes effect on y one cycle later. It causes no extra step and no lost dwell cycles.
- rst mid-scan or mid-handshake: all outputs return to reset values on the next edge. No pending accept survives.

## Configuration
- DECODER_SCAN_EN defined: full behaviour above.
- DECODER_SCAN_EN undefined:
  - SCAN state, dwell counter, and wrap logic are removed.
  - mode and dwell are ignored. wrap is tied 0.
  - a_ready = !rst.
  - FSM is IDLE/DIRECT only.

## Test plan
- Reset: after rst, y=0, y_valid=0, idx=0, wrap=0. Then N=3, a=5 with a_valid → next cycle y=8'b0010_0000, idx=5, y_valid=1.
- Back-to-back accepts a=0..7 on consecutive cycles → y walks 0x01..0x80, one per cycle, each exactly one-hot.
- Scan, N=3, dwell=3 → each bit held 3 cycles. wrap pulses once per 24 cycles, aligned with y=0x01. a_ready=0 throughout.
- dwell=0 in scan → steps every cycle. en dropped at idx=4 for 5 cycles → y=0 after one cycle; on resume y=0x10 completes its remaining dwell.
- mode 1→0 at idx=6 → y stays 0x40, a_ready=1 the next cycle. Then a=2 accepted → y=0x04.
- rst asserted mid-scan at idx=3 → next cycle all outputs 0. Build without DECODER_SCAN_EN: mode=1 has no effect, direct decode still works.

Source files
------------

// File: rtl/decoder_nto2n_seq_if.sv
// Select handshake and decoded-output bundle shared by decoder_nto2n_seq and its driver.
interface decoder_nto2n_seq_if #(
   parameter int N = 3
);
   logic [N-1:0]      a;
   logic              a_valid;
   logic              a_ready;
   logic [(1<<N)-1:0] y;
   logic [N-1:0]      idx;
   logic              y_valid;
   logic              wrap;

   modport master (output a, a_valid, input a_ready, y, idx, y_valid, wrap);
   modport slave  (input a, a_valid, output a_ready, y, idx, y_valid, wrap);
endinterface

// File: rtl/decoder_nto2n_seq.sv
// Registered N-to-2^N one-hot decoder with valid/ready select, output enable and auto-scan.
// Auto-scan (SCAN state, dwell counter, wrap pulse) exists only when DECODER_SCAN_EN is defined.
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | nothing decoded since reset; y_valid stays low
// DIRECT | holding the last accepted select
// SCAN   | stepping idx 0..2^N-1, each held max(dwell,1) enabled cycles
module decoder_nto2n_seq #(
   parameter int N       = 3,
   parameter int DWELL_W = 8
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               en,
   input  logic               mode,
   input  logic [DWELL_W-1:0] dwell,
   decoder_nto2n_seq_if.slave bus
);
   localparam int W = 1 << N;

`ifdef DECODER_SCAN_EN
   typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_DIRECT = 2'd1, ST_SCAN = 2'd2} state_t;
`else
   typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_DIRECT = 1'b1} state_t;
`endif

   state_t         state_q, state_d;
   logic [N-1:0]   idx_q, idx_d;
   logic [W-1:0]   y_q, y_d;
   logic           y_valid_q, y_valid_d;
   logic           a_ready;
   logic           accept;

`ifdef DECODER_SCAN_EN
   logic [DWELL_W-1:0] cnt_q, cnt_d;
   logic [DWELL_W-1:0] dwell_m1;
   logic               wrap_q, wrap_d;

   assign a_ready  = (state_q != ST_SCAN) && !mode && !rst;
   // dwell of 0 behaves like 1, so the terminal count never underflows
   assign dwell_m1 = (dwell == '0) ? '0 : dwell - DWELL_W'(1);
`else
   logic unused_cfg;

   assign unused_cfg = ^{mode, dwell};
   assign a_ready    = !rst;
`endif

   assign accept = bus.a_valid && a_ready;

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
`ifdef DECODER_SCAN_EN
      cnt_d   = cnt_q;
      wrap_d  = 1'b0;
      // en low freezes state, index and count so the sweep resumes seamlessly
      if (en) begin
         case (state_q)
            ST_SCAN: begin
               if (!mode) begin
                  state_d = ST_DIRECT;
               end else if (cnt_q >= dwell_m1) begin
                  cnt_d  = '0;
                  idx_d  = idx_q + N'(1);
                  wrap_d = &idx_q;
               end else begin
                  cnt_d = cnt_q + DWELL_W'(1);
               end
            end
            default: begin
               if (mode) begin
                  state_d = ST_SCAN;
                  idx_d   = '0;
                  cnt_d   = '0;
               end
            end
         endcase
      end
`endif
      // accepts are honoured even while blanked; a_ready already excludes scan
      if (accept) begin
         state_d = ST_DIRECT;
         idx_d   = bus.a;
      end
      y_d        = '0;
      y_d[idx_d] = en;
      y_valid_d  = en && (state_d != ST_IDLE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         idx_q     <= '0;
         y_q       <= '0;
         y_valid_q <= 1'b0;
`ifdef DECODER_SCAN_EN
         cnt_q     <= '0;
         wrap_q    <= 1'b0;
`endif
      end else begin
         state_q   <= state_d;
         idx_q     <= idx_d;
         y_q       <= y_d;
         y_valid_q <= y_valid_d;
`ifdef DECODER_SCAN_EN
         cnt_q     <= cnt_d;
         wrap_q    <= wrap_d;
`endif
      end
   end

   assign bus.a_ready = a_ready;
   assign bus.y       = y_q;
   assign bus.idx     = idx_q;
   assign bus.y_valid = y_valid_q;
`ifdef DECODER_SCAN_EN
   assign bus.wrap    = wrap_q;
`else
   assign bus.wrap    = 1'b0;
`endif
endmodule
